// File: rtl/rbmm_arbiter.sv
// rbmm_arbiter: round-robin front end sharing one fixed-latency row multiply unit between two requesters
module rbmm_arbiter #(
  parameter int W   = 16,
  parameter int LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  req0_v,
  input  logic [3:0][W-1:0]     req0_a,
  output logic                  req0_rdy,
  input  logic                  req1_v,
  input  logic [3:0][W-1:0]     req1_a,
  output logic                  req1_rdy,
  output logic [3:0][W-1:0]     mm_a,
  output logic                  mm_v,
  input  logic [3:0][2*W-1:0]   mm_out,
  input  logic                  mm_out_v,
  output logic                  rsp0_v,
  output logic                  rsp1_v,
  output logic [3:0][2*W-1:0]   rsp_data,
  output logic                  idle,
  output logic                  err
);
  // last holds the id granted most recently; its reset value 1 makes requester 0 win the first tie
  logic           last;
  logic           mm_id;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;
  logic           hit;
  logic           miss;
  // Grant: a lone valid requester wins, a tie goes to the one not granted last; nothing while in reset
  always_comb begin
    req0_rdy = rst && en && req0_v && (!req1_v || last);
    req1_rdy = rst && en && req1_v && (!req0_v || !last);
  end
  // The oldest tag sits in the top stage exactly when its result strobe is due
  always_comb begin
    hit  = mm_out_v && tag_v[LAT-1];
    miss = mm_out_v != tag_v[LAT-1];
    idle = !mm_v && !(|tag_v);
  end
  // Issue register, tag shift pipeline, response register and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last     <= 1'b1;
      mm_v     <= 1'b0;
      mm_id    <= 1'b0;
      mm_a     <= '0;
      tag_v    <= '0;
      tag_id   <= '0;
      rsp0_v   <= 1'b0;
      rsp1_v   <= 1'b0;
      rsp_data <= '0;
      err      <= 1'b0;
    end else begin
      mm_v <= req0_rdy || req1_rdy;
      if (req0_rdy || req1_rdy) begin
        mm_a  <= req1_rdy ? req1_a : req0_a;
        mm_id <= req1_rdy;
        last  <= req1_rdy;
      end
      tag_v  <= (tag_v << 1) | LAT'(mm_v);
      tag_id <= (tag_id << 1) | LAT'(mm_id);
      rsp0_v <= hit && !tag_id[LAT-1];
      rsp1_v <= hit && tag_id[LAT-1];
      if (hit) rsp_data <= mm_out;
      if (miss) err <= 1'b1;
    end
  end
endmodule
